// File: rtl/line_buffer_3row.sv
// 3-row vertical window generator: emits {row n-2, row n-1, row n} per pixel, one clk after the pixel.
// Optional macro BORDER_REPLICATE_EN replicates top-border rows instead of zero-filling them.
module line_buffer_3row #(
  parameter int IMG_WIDTH = 640,
  parameter int ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        en,
  input  logic [7:0]  in_data,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_en,
  output logic [23:0] out_data,
  output logic        line_ovf
);

  logic [7:0]        r_mem1 [IMG_WIDTH];
  logic [7:0]        r_mem2 [IMG_WIDTH];
  logic [ADDR_W-1:0] r_col;
  logic [1:0]        r_rows_filled;
  logic              r_en_d;
  logic              r_vsync_d;
  logic              r_full;
  logic [23:0]       r_out;
  logic              r_line_ovf;

  logic              w_frame_start;
  logic              w_line_end;
  logic              w_last_col;
  logic [7:0]        w_rd1;
  logic [7:0]        w_rd2;
  logic [7:0]        w_fill1;
  logic [7:0]        w_fill2;
  logic [7:0]        w_row1;
  logic [7:0]        w_row2;

  // Edge detection, memory read port and border fill selection.
  always_comb begin
    w_frame_start = vsync & ~r_vsync_d;
    w_line_end    = r_en_d & ~en;
    w_last_col    = (r_col == ADDR_W'(IMG_WIDTH - 1));
    w_rd1         = r_mem1[r_col];
    w_rd2         = r_mem2[r_col];
`ifdef BORDER_REPLICATE_EN
    w_fill1 = in_data;
    if (r_rows_filled >= 2'd1) begin
      w_fill2 = w_rd1;
    end else begin
      w_fill2 = in_data;
    end
`else
    w_fill1 = 8'd0;
    w_fill2 = 8'd0;
`endif
    if (r_rows_filled >= 2'd1) begin
      w_row1 = w_rd1;
    end else begin
      w_row1 = w_fill1;
    end
    if (r_rows_filled >= 2'd2) begin
      w_row2 = w_rd2;
    end else begin
      w_row2 = w_fill2;
    end
  end

  // Line memories: not reset, stale content is masked by r_rows_filled.
  always_ff @(posedge clk) begin
    if (en) begin
      r_mem1[r_col] <= in_data;
      r_mem2[r_col] <= w_rd1;
    end
  end

  // Column/row bookkeeping and the registered output stage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_col         <= '0;
      r_rows_filled <= 2'd0;
      r_en_d        <= 1'b0;
      r_vsync_d     <= 1'b0;
      r_full        <= 1'b0;
      r_out         <= 24'd0;
      r_line_ovf    <= 1'b0;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_en          <= 1'b0;
    end else begin
      r_en_d     <= en;
      r_vsync_d  <= vsync;
      o_hsync    <= hsync;
      o_vsync    <= vsync;
      o_en       <= en;
      // r_full marks that the last column was taken; the next pixel is an overflow.
      r_line_ovf <= en & r_full;
      if (en) begin
        r_out <= {w_row2, w_row1, in_data};
      end
      if (w_frame_start) begin
        r_col         <= '0;
        r_rows_filled <= 2'd0;
        r_full        <= 1'b0;
      end else if (w_line_end) begin
        r_col  <= '0;
        r_full <= 1'b0;
        if (r_rows_filled != 2'd2) begin
          r_rows_filled <= r_rows_filled + 2'd1;
        end
      end else if (en) begin
        r_full <= w_last_col;
        if (w_last_col) begin
          r_col <= '0;
        end else begin
          r_col <= r_col + ADDR_W'(1);
        end
      end
    end
  end

  assign out_data = r_out;
  assign line_ovf = r_line_ovf;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Randomized self-checking bench for line_buffer_3row (IMG_WIDTH=4), against a line-history model.
module tb_line_buffer_3row;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        hsync = 1'b0, vsync = 1'b0, en = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        o_hsync, o_vsync, o_en, line_ovf;
  logic [23:0] out_data;

  int checks = 0;
  int failures = 0;

  // model state
  int          m_col, m_rows, m_full;
  logic        m_en_d, m_vs_d;
  logic [7:0]  m_prev1 [W];
  logic [7:0]  m_prev2 [W];
  logic [23:0] m_out;
  logic [27:0] exp_v;

  line_buffer_3row #(.IMG_WIDTH(W), .ADDR_W(2)) dut (
    .clk(clk), .nrst(nrst), .hsync(hsync), .vsync(vsync), .en(en), .in_data(in_data),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_en(o_en), .out_data(out_data), .line_ovf(line_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_col = 0; m_rows = 0; m_full = 0; m_en_d = 1'b0; m_vs_d = 1'b0; m_out = 24'd0;
  endtask

  // Drives one clk of input, advances the model; expected outputs land in exp_v.
  task automatic drive(input logic e, input logic [7:0] d, input logic hs, input logic vs);
    logic [7:0] up1, up2;
    logic       ovf;
    ovf = 1'b0;
    if (e) begin
`ifdef BORDER_REPLICATE_EN
      up1 = (m_rows >= 1) ? m_prev1[m_col] : d;
      up2 = (m_rows >= 2) ? m_prev2[m_col] : ((m_rows >= 1) ? m_prev1[m_col] : d);
`else
      up1 = (m_rows >= 1) ? m_prev1[m_col] : 8'd0;
      up2 = (m_rows >= 2) ? m_prev2[m_col] : 8'd0;
`endif
      m_out = {up2, up1, d};
      ovf = (m_full != 0);
      m_prev2[m_col] = m_prev1[m_col];
      m_prev1[m_col] = d;
    end
    if (vs && !m_vs_d) begin
      m_col = 0; m_rows = 0; m_full = 0;
    end else if (m_en_d && !e) begin
      m_col = 0; m_full = 0;
      if (m_rows < 2) m_rows = m_rows + 1;
    end else if (e) begin
      m_full = (m_col == W - 1) ? 1 : 0;
      m_col = (m_col + 1) % W;
    end
    m_en_d = e; m_vs_d = vs;
    exp_v = {vs, hs, e, ovf, m_out};
    en = e; in_data = d; hsync = hs; vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    frame_start();
    for (int c = 0; c < 3; c++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
    #3;
    nrst = 1'b0;
    #1;
    checks++;
    if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== 28'd0) begin
      failures++;
      $display("FAIL reset_async: got %h want 0", {o_vsync, o_hsync, o_en, line_ovf, out_data});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== 28'd0) begin
      failures++;
      $display("FAIL reset_held: got %h want 0", {o_vsync, o_hsync, o_en, line_ovf, out_data});
    end
    en = 1'b0; vsync = 1'b0; hsync = 1'b0;
    model_reset();
    #2;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < W; c++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL reset_first_line: got %h want %h", {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
`ifndef BORDER_REPLICATE_EN
      checks++;
      if (out_data[23:8] !== 16'd0) begin
        failures++;
        $display("FAIL reset_upper_zero: got %h want 0000", out_data[23:8]);
      end
`endif
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_three_lines();
    frame_start();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b1, 8'(16 * r + c), 1'b1, 1'b0);
        checks++;
        if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
          failures++;
          $display("FAIL three_lines r%0d c%0d: got %h want %h", r, c, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
        end
        if (r == 2 && c == 1) begin
          checks++;
          if (out_data !== 24'h011121) begin
            failures++;
            $display("FAIL window_l2c1: got %h want 011121", out_data);
          end
        end
        if (r == 1 && c == 0) begin
          checks++;
          if (out_data !== 24'h000010) begin
            failures++;
            $display("FAIL window_l1c0: got %h want 000010", out_data);
          end
        end
      end
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL three_lines_gap r%0d: got %h want %h", r, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
    end
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    frame_start();
    for (int c = 0; c < W + 1; c++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      pulses += int'(line_ovf);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL overflow c%0d: got %h want %h", c, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    pulses += int'(line_ovf);
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL overflow_pulses: got %0d want 1", pulses);
    end
    for (int c = 0; c < W; c++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL overflow_next c%0d: got %h want %h", c, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_vsync_restart();
    frame_start();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < W; c++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      // last line ends in the same clk as the vsync rising edge
      drive(1'b0, 8'd0, 1'b0, (r == 5) ? 1'b1 : 1'b0);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL vsync_lines r%0d: got %h want %h", r, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
    end
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    for (int c = 0; c < W; c++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL vsync_restart c%0d: got %h want %h", c, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
`ifndef BORDER_REPLICATE_EN
      checks++;
      if (out_data[23:8] !== 16'd0) begin
        failures++;
        $display("FAIL vsync_upper_zero: got %h want 0000", out_data[23:8]);
      end
`endif
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_en_gap();
    logic [23:0] held;
    frame_start();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      drive(1'b0, 8'd0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      held = out_data;
      drive(1'b0, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if (out_data !== held) begin
        failures++;
        $display("FAIL gap_hold: got %h want %h", out_data, held);
      end
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL gap_resume k%0d: got %h want %h", k, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic e, vs;
    for (int i = 0; i < 600; i++) begin
      e  = ($urandom % 6) != 0;
      vs = ($urandom % 50) == 0;
      drive(e, 8'($urandom), 1'($urandom), vs);
      checks++;
      if ({o_vsync, o_hsync, o_en, line_ovf, out_data} !== exp_v) begin
        failures++;
        $display("FAIL random i%0d: got %h want %h", i, {o_vsync, o_hsync, o_en, line_ovf, out_data}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_lines();
    test_overflow();
    test_vsync_restart();
    test_en_gap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
